// File: rtl/triangle_setup.sv
// Triangle setup: floors three Q16.16 vertices to pixels and derives edge coefficients, area2 and a clamped bbox; culls degenerate and off-screen triangles.
// Latency: start sampled in IDLE at cycle T, done/valid pulse at T+5; busy is high T+1..T+5.
// Backpressure: none; start is ignored while busy, and results hold until the next accepted start.
//
// Ports: clk_in/rst_in (async active-low), start, projected_verts[v] = {inv_w, z, y, x};
//        edge_a/b/c, area2, bbox_*, vert_z/vert_inv_w, valid, busy, done, status.
// Optional feature macro: BACKFACE_CULL_EN. When defined, negative-area triangles are culled
// with status 2. When undefined, they are re-wound by swapping vertices 1 and 2.
module triangle_setup #(
    parameter int COORD_WIDTH = 32,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180,
    parameter int PIX_WIDTH   = 16
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     start,
    input  logic signed [2:0][3:0][COORD_WIDTH-1:0]  projected_verts,
    output logic signed [2:0][PIX_WIDTH:0]           edge_a,
    output logic signed [2:0][PIX_WIDTH:0]           edge_b,
    output logic signed [2:0][2*PIX_WIDTH:0]         edge_c,
    output logic signed [2*PIX_WIDTH+2:0]            area2,
    output logic        [PIX_WIDTH-1:0]              bbox_min_x,
    output logic        [PIX_WIDTH-1:0]              bbox_max_x,
    output logic        [PIX_WIDTH-1:0]              bbox_min_y,
    output logic        [PIX_WIDTH-1:0]              bbox_max_y,
    output logic signed [2:0][COORD_WIDTH-1:0]       vert_z,
    output logic signed [2:0][COORD_WIDTH-1:0]       vert_inv_w,
    output logic                                     valid,
    output logic                                     busy,
    output logic                                     done,
    output logic        [1:0]                        status
);

    localparam int FRAC = COORD_WIDTH / 2;
    localparam int IW   = COORD_WIDTH - FRAC;
    localparam int AW   = PIX_WIDTH + 1;
    localparam int CW   = 2 * PIX_WIDTH + 1;
    localparam int SW   = 2 * PIX_WIDTH + 3;
    localparam logic signed [PIX_WIDTH-1:0] X_MAX = PIX_WIDTH'(FB_WIDTH - 1);
    localparam logic signed [PIX_WIDTH-1:0] Y_MAX = PIX_WIDTH'(FB_HEIGHT - 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_DEGEN    = 2'd1;
    localparam logic [1:0] ST_BACKFACE = 2'd2;
    localparam logic [1:0] ST_OFFSCRN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EDGE,
        S_AREA,
        S_CULL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Captured integer parts and pass-through attributes
    logic signed [IW-1:0]          r_xi [3];
    logic signed [IW-1:0]          r_yi [3];
    logic signed [COORD_WIDTH-1:0] r_z  [3];
    logic signed [COORD_WIDTH-1:0] r_w  [3];

    // Pipeline of intermediate results, one stage per state
    logic signed [PIX_WIDTH-1:0]   r_px [3];
    logic signed [PIX_WIDTH-1:0]   r_py [3];
    logic signed [AW-1:0]          r_a  [3];
    logic signed [AW-1:0]          r_b  [3];
    logic signed [CW-1:0]          r_c  [3];
    logic signed [SW-1:0]          r_area;
    logic signed [PIX_WIDTH-1:0]   r_min_x;
    logic signed [PIX_WIDTH-1:0]   r_max_x;
    logic signed [PIX_WIDTH-1:0]   r_min_y;
    logic signed [PIX_WIDTH-1:0]   r_max_y;

    logic signed [AW-1:0]          w_a  [3];
    logic signed [AW-1:0]          w_b  [3];
    logic signed [CW-1:0]          w_c  [3];
    logic signed [SW-1:0]          w_area;
    logic                          w_offscreen;
    logic                          w_swap;
    logic [1:0]                    w_status;

    function automatic logic signed [PIX_WIDTH-1:0] min3(
        input logic signed [PIX_WIDTH-1:0] a,
        input logic signed [PIX_WIDTH-1:0] b,
        input logic signed [PIX_WIDTH-1:0] c
    );
        logic signed [PIX_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic logic signed [PIX_WIDTH-1:0] max3(
        input logic signed [PIX_WIDTH-1:0] a,
        input logic signed [PIX_WIDTH-1:0] b,
        input logic signed [PIX_WIDTH-1:0] c
    );
        logic signed [PIX_WIDTH-1:0] m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    function automatic logic [PIX_WIDTH-1:0] clamp(
        input logic signed [PIX_WIDTH-1:0] v,
        input logic signed [PIX_WIDTH-1:0] hi
    );
        logic [PIX_WIDTH-1:0] r;
        if (v < 0) begin
            r = '0;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Edge i runs from vertex i to vertex (i+1)%3
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        localparam int GJ = (gi + 1) % 3;
        assign w_a[gi] = AW'(r_py[gi]) - AW'(r_py[GJ]);
        assign w_b[gi] = AW'(r_px[GJ]) - AW'(r_px[gi]);
        assign w_c[gi] = CW'(r_px[gi]) * CW'(r_py[GJ]) - CW'(r_px[GJ]) * CW'(r_py[gi]);
    end

    assign w_area = SW'(r_c[0]) + SW'(r_c[1]) + SW'(r_c[2]);

    // Off-screen uses the raw (unclamped) box: fully left/right/above/below the framebuffer
    assign w_offscreen = (r_max_x < 0) || (r_min_x > X_MAX) ||
                         (r_max_y < 0) || (r_min_y > Y_MAX);

    always_comb begin
        w_status = ST_OK;
        w_swap   = 1'b0;
`ifdef BACKFACE_CULL_EN
        if (r_area == '0) begin
            w_status = ST_DEGEN;
        end else if (r_area < 0) begin
            w_status = ST_BACKFACE;
        end else if (w_offscreen) begin
            w_status = ST_OFFSCRN;
        end
`else
        // Negative winding is fixed up rather than culled; off-screen still culls after re-winding
        if (r_area == '0) begin
            w_status = ST_DEGEN;
        end else if (w_offscreen) begin
            w_status = ST_OFFSCRN;
        end
        w_swap = (r_area < 0);
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_EDGE;
            S_EDGE:  w_next = S_AREA;
            S_AREA:  w_next = S_CULL;
            S_CULL:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 3; i++) begin
                r_xi[i] <= '0;
                r_yi[i] <= '0;
                r_z[i]  <= '0;
                r_w[i]  <= '0;
                r_px[i] <= '0;
                r_py[i] <= '0;
                r_a[i]  <= '0;
                r_b[i]  <= '0;
                r_c[i]  <= '0;
            end
            r_area     <= '0;
            r_min_x    <= '0;
            r_max_x    <= '0;
            r_min_y    <= '0;
            r_max_y    <= '0;
            edge_a     <= '0;
            edge_b     <= '0;
            edge_c     <= '0;
            area2      <= '0;
            bbox_min_x <= '0;
            bbox_max_x <= '0;
            bbox_min_y <= '0;
            bbox_max_y <= '0;
            vert_z     <= '0;
            vert_inv_w <= '0;
            status     <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 3; i++) begin
                            r_xi[i] <= projected_verts[i][0][COORD_WIDTH-1:FRAC];
                            r_yi[i] <= projected_verts[i][1][COORD_WIDTH-1:FRAC];
                            r_z[i]  <= projected_verts[i][2];
                            r_w[i]  <= projected_verts[i][3];
                        end
                    end
                end
                S_LOAD: begin
                    // Integer part of Q16.16 is already the floor; resize keeps the sign
                    for (int i = 0; i < 3; i++) begin
                        r_px[i] <= PIX_WIDTH'(r_xi[i]);
                        r_py[i] <= PIX_WIDTH'(r_yi[i]);
                    end
                end
                S_EDGE: begin
                    for (int i = 0; i < 3; i++) begin
                        r_a[i] <= w_a[i];
                        r_b[i] <= w_b[i];
                        r_c[i] <= w_c[i];
                    end
                end
                S_AREA: begin
                    r_area  <= w_area;
                    r_min_x <= min3(r_px[0], r_px[1], r_px[2]);
                    r_max_x <= max3(r_px[0], r_px[1], r_px[2]);
                    r_min_y <= min3(r_py[0], r_py[1], r_py[2]);
                    r_max_y <= max3(r_py[0], r_py[1], r_py[2]);
                end
                S_CULL: begin
                    // Swapping v1/v2 turns edge i into the reverse of edge 2-i, hence
                    // the index mirror plus negation; vertex slots 1 and 2 exchange.
                    for (int i = 0; i < 3; i++) begin
                        edge_a[i]     <= w_swap ? -r_a[2-i] : r_a[i];
                        edge_b[i]     <= w_swap ? -r_b[2-i] : r_b[i];
                        edge_c[i]     <= w_swap ? -r_c[2-i] : r_c[i];
                        vert_z[i]     <= w_swap ? r_z[(3-i)%3] : r_z[i];
                        vert_inv_w[i] <= w_swap ? r_w[(3-i)%3] : r_w[i];
                    end
                    area2      <= w_swap ? -r_area : r_area;
                    bbox_min_x <= clamp(r_min_x, X_MAX);
                    bbox_max_x <= clamp(r_max_x, X_MAX);
                    bbox_min_y <= clamp(r_min_y, Y_MAX);
                    bbox_max_y <= clamp(r_max_y, Y_MAX);
                    status     <= w_status;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign valid = done && (status == ST_OK);

endmodule

// File: tb/tb_triangle_setup.sv
module tb_triangle_setup;

    typedef logic [2:0][3:0][31:0] verts_t;

    logic                        clk_in = 1'b0;
    logic                        rst_in;
    logic                        start;
    logic signed [2:0][3:0][31:0] projected_verts;
    logic signed [2:0][16:0]     edge_a;
    logic signed [2:0][16:0]     edge_b;
    logic signed [2:0][32:0]     edge_c;
    logic signed [34:0]          area2;
    logic [15:0]                 bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
    logic signed [2:0][31:0]     vert_z;
    logic signed [2:0][31:0]     vert_inv_w;
    logic                        valid, busy, done;
    logic [1:0]                  status;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    triangle_setup dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start           (start),
        .projected_verts (projected_verts),
        .edge_a          (edge_a),
        .edge_b          (edge_b),
        .edge_c          (edge_c),
        .area2           (area2),
        .bbox_min_x      (bbox_min_x),
        .bbox_max_x      (bbox_max_x),
        .bbox_min_y      (bbox_min_y),
        .bbox_max_y      (bbox_max_y),
        .vert_z          (vert_z),
        .vert_inv_w      (vert_inv_w),
        .valid           (valid),
        .busy            (busy),
        .done            (done),
        .status          (status)
    );

    function automatic verts_t mk(input int x0, input int y0, input int x1,
                                  input int y1, input int x2, input int y2);
        verts_t v;
        int xs[3];
        int ys[3];
        xs = '{x0, x1, x2};
        ys = '{y0, y1, y2};
        for (int i = 0; i < 3; i++) begin
            v[i][0] = xs[i] << 16;
            v[i][1] = ys[i] << 16;
            v[i][2] = 32'h100 + i;
            v[i][3] = 32'h200 + i;
        end
        return v;
    endfunction

    // Issues one start and returns the cycle count to done (-1 on timeout)
    task automatic launch(input verts_t v, output int lat, output bit busy_ok);
        @(negedge clk_in);
        projected_verts = v;
        start = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        start = 1'b0;
        projected_verts = '0;
        #2 rst_in = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (status !== 2'd0) begin errors++; $display("FAIL reset_status got=%0d exp=0", status); end
        checks++; if (area2 !== '0) begin errors++; $display("FAIL reset_area2 got=%0d exp=0", area2); end
        checks++; if (edge_c !== '0) begin errors++; $display("FAIL reset_edge_c got=%h exp=0", edge_c); end
        checks++; if (bbox_max_x !== '0) begin errors++; $display("FAIL reset_bbox got=%0d exp=0", bbox_max_x); end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        logic signed [2:0][16:0] ea, eb;
        logic signed [2:0][32:0] ec;
        logic signed [2:0][31:0] ez;
        ea[0] = 17'sd0;   ea[1] = -17'sd10; ea[2] = 17'sd10;
        eb[0] = 17'sd10;  eb[1] = -17'sd10; eb[2] = 17'sd0;
        ec[0] = -33'sd100; ec[1] = 33'sd300; ec[2] = -33'sd100;
        ez[0] = 32'h100;  ez[1] = 32'h101;  ez[2] = 32'h102;
        launch(mk(10, 10, 20, 10, 10, 20), lat, bok);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", valid); end
        checks++; if (status !== 2'd0) begin errors++; $display("FAIL basic_status got=%0d exp=0", status); end
        checks++; if (edge_a !== ea) begin errors++; $display("FAIL basic_edge_a got=%h exp=%h", edge_a, ea); end
        checks++; if (edge_b !== eb) begin errors++; $display("FAIL basic_edge_b got=%h exp=%h", edge_b, eb); end
        checks++; if (edge_c !== ec) begin errors++; $display("FAIL basic_edge_c got=%h exp=%h", edge_c, ec); end
        checks++; if (area2 !== 35'sd100) begin errors++; $display("FAIL basic_area2 got=%0d exp=100", area2); end
        checks++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {16'd10, 16'd20, 16'd10, 16'd20}) begin
            errors++; $display("FAIL basic_bbox got=%0d..%0d,%0d..%0d exp=10..20,10..20", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y);
        end
        checks++; if (vert_z !== ez) begin errors++; $display("FAIL basic_vert_z got=%h exp=%h", vert_z, ez); end
        @(negedge clk_in);
        checks++; if ({done, busy, valid} !== 3'b000) begin errors++; $display("FAIL basic_after_done got=%b exp=000", {done, busy, valid}); end
        checks++; if (area2 !== 35'sd100) begin errors++; $display("FAIL basic_hold got=%0d exp=100", area2); end
    endtask

    task automatic test_winding();
        int lat;
        bit bok;
        logic signed [2:0][16:0] ea;
        logic signed [2:0][31:0] ez, ew;
        launch(mk(10, 10, 10, 20, 20, 10), lat, bok);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wind_latency got=%0d exp=5", lat); end
`ifdef BACKFACE_CULL_EN
        ea[0] = -17'sd10; ea[1] = 17'sd10; ea[2] = 17'sd0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wind_valid got=%b exp=0", valid); end
        checks++; if (status !== 2'd2) begin errors++; $display("FAIL wind_status got=%0d exp=2", status); end
        checks++; if (area2 !== -35'sd100) begin errors++; $display("FAIL wind_area2 got=%0d exp=-100", area2); end
        checks++; if (edge_a !== ea) begin errors++; $display("FAIL wind_edge_a got=%h exp=%h", edge_a, ea); end
        ez = '0; ew = '0;
`else
        ea[0] = 17'sd0; ea[1] = -17'sd10; ea[2] = 17'sd10;
        ez[0] = 32'h100; ez[1] = 32'h102; ez[2] = 32'h101;
        ew[0] = 32'h200; ew[1] = 32'h202; ew[2] = 32'h201;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wind_valid got=%b exp=1", valid); end
        checks++; if (status !== 2'd0) begin errors++; $display("FAIL wind_status got=%0d exp=0", status); end
        checks++; if (area2 !== 35'sd100) begin errors++; $display("FAIL wind_area2 got=%0d exp=100", area2); end
        checks++; if (edge_a !== ea) begin errors++; $display("FAIL wind_edge_a got=%h exp=%h", edge_a, ea); end
        checks++; if (edge_c[1] !== 33'sd300) begin errors++; $display("FAIL wind_edge_c1 got=%0d exp=300", edge_c[1]); end
        checks++; if (edge_b[0] !== 17'sd10) begin errors++; $display("FAIL wind_edge_b0 got=%0d exp=10", edge_b[0]); end
        checks++; if (vert_z !== ez) begin errors++; $display("FAIL wind_vert_z got=%h exp=%h", vert_z, ez); end
        checks++; if (vert_inv_w !== ew) begin errors++; $display("FAIL wind_inv_w got=%h exp=%h", vert_inv_w, ew); end
`endif
    endtask

    task automatic test_degenerate();
        int lat;
        bit bok;
        launch(mk(0, 0, 5, 5, 10, 10), lat, bok);
        checks++; if (lat !== 5) begin errors++; $display("FAIL degen_latency got=%0d exp=5", lat); end
        checks++; if (status !== 2'd1) begin errors++; $display("FAIL degen_status got=%0d exp=1", status); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL degen_valid got=%b exp=0", valid); end
        checks++; if (area2 !== '0) begin errors++; $display("FAIL degen_area2 got=%0d exp=0", area2); end
    endtask

    task automatic test_offscreen();
        int lat;
        bit bok;
        launch(mk(-50, 10, -40, 10, -50, 20), lat, bok);
        checks++; if (lat !== 5) begin errors++; $display("FAIL off_latency got=%0d exp=5", lat); end
        checks++; if (status !== 2'd3) begin errors++; $display("FAIL off_status got=%0d exp=3", status); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL off_valid got=%b exp=0", valid); end
        launch(mk(-5, -5, 400, -5, -5, 300), lat, bok);
        checks++; if (status !== 2'd0) begin errors++; $display("FAIL clamp_status got=%0d exp=0", status); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL clamp_valid got=%b exp=1", valid); end
        checks++; if (area2 !== 35'sd123525) begin errors++; $display("FAIL clamp_area2 got=%0d exp=123525", area2); end
        checks++; if (edge_c[1] !== 33'sd119975) begin errors++; $display("FAIL clamp_edge_c1 got=%0d exp=119975", edge_c[1]); end
        checks++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {16'd0, 16'd319, 16'd0, 16'd179}) begin
            errors++; $display("FAIL clamp_bbox got=%0d..%0d,%0d..%0d exp=0..319,0..179", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y);
        end
    endtask

    task automatic test_floor();
        int lat;
        bit bok;
        verts_t v;
        v = mk(10, 10, 20, 10, 10, 20);
        v[0][0] = 32'h000A8000;
        launch(v, lat, bok);
        checks++; if (edge_b[0] !== 17'sd10) begin errors++; $display("FAIL floor_pos_b0 got=%0d exp=10", edge_b[0]); end
        checks++; if (area2 !== 35'sd100) begin errors++; $display("FAIL floor_pos_area2 got=%0d exp=100", area2); end
        v[0][0] = 32'hFFFF8000;
        launch(v, lat, bok);
        checks++; if (edge_b[0] !== 17'sd21) begin errors++; $display("FAIL floor_neg_b0 got=%0d exp=21", edge_b[0]); end
        checks++; if (area2 !== 35'sd210) begin errors++; $display("FAIL floor_neg_area2 got=%0d exp=210", area2); end
        checks++; if (bbox_min_x !== 16'd0) begin errors++; $display("FAIL floor_neg_bbox got=%0d exp=0", bbox_min_x); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        bit seen;
        @(negedge clk_in);
        projected_verts = mk(10, 10, 20, 10, 10, 20);
        start = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0;
        @(negedge clk_in);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst_in = 1'b0;
        #1;
        checks++; if ({busy, done, valid} !== 3'b000) begin errors++; $display("FAIL mid_ctrl got=%b exp=000", {busy, done, valid}); end
        checks++; if (area2 !== '0) begin errors++; $display("FAIL mid_area2 got=%0d exp=0", area2); end
        checks++; if (edge_b !== '0) begin errors++; $display("FAIL mid_edge_b got=%h exp=0", edge_b); end
        checks++; if (vert_z !== '0) begin errors++; $display("FAIL mid_vert_z got=%h exp=0", vert_z); end
        checks++; if (bbox_min_x !== '0) begin errors++; $display("FAIL mid_bbox got=%0d exp=0", bbox_min_x); end
        @(negedge clk_in);
        rst_in = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done got=%b exp=0", seen); end
        launch(mk(10, 10, 20, 10, 10, 20), lat, bok);
        checks++; if (lat !== 5) begin errors++; $display("FAIL mid_restart_latency got=%0d exp=5", lat); end
        checks++; if (area2 !== 35'sd100) begin errors++; $display("FAIL mid_restart_area2 got=%0d exp=100", area2); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit seen;
        @(negedge clk_in);
        projected_verts = mk(10, 10, 20, 10, 10, 20);
        start = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0;
        @(negedge clk_in);
        projected_verts = mk(0, 0, 5, 5, 10, 10);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        lat = -1;
        for (int n = 3; n <= 20; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk_in);
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL ign_latency got=%0d exp=5", lat); end
        checks++; if (status !== 2'd0) begin errors++; $display("FAIL ign_status got=%0d exp=0", status); end
        checks++; if (area2 !== 35'sd100) begin errors++; $display("FAIL ign_area2 got=%0d exp=100", area2); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ign_second_run got=%b exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_winding();
        test_degenerate();
        test_offscreen();
        test_floor();
        test_reset_mid();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/triangle_setup.md
Name: triangle_setup

Overview:
Downstream consumer of the vertex projection stage. Takes the three screen-space vertices {inv_w, z, y, x} (Q16.16) produced by projection and converts them to integer pixel coordinates. From these it computes edge-function coefficients, the doubled signed area, and a framebuffer-clamped bounding box. It culls degenerate, back-facing and fully off-screen triangles, then hands an accepted triangle to the rasterizer with per-vertex z and inv_w passed through for interpolation.

Parameters:
COORD_WIDTH, 32, width of Q16.16 input words; fraction bits = COORD_WIDTH/2.
FB_WIDTH, 320, framebuffer width in pixels.
FB_HEIGHT, 180, framebuffer height in pixels.
PIX_WIDTH, 16, signed integer pixel coordinate width.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
projected_verts  input  [2:0][3:0][COORD_WIDTH-1:0] signed  per vertex {inv_w, z, y, x}, Q16.16.
edge_a  output  [2:0][PIX_WIDTH:0] signed  edge i: A = y_i - y_j, where j = (i+1)%3.
edge_b  output  [2:0][PIX_WIDTH:0] signed  edge i: B = x_j - x_i.
edge_c  output  [2:0][2*PIX_WIDTH:0] signed  edge i: C = x_i*y_j - x_j*y_i.
area2  output  [2*PIX_WIDTH+2:0] signed  C0+C1+C2 (twice the signed area).
bbox_min_x, bbox_max_x  output  [PIX_WIDTH-1:0]  clamped to [0, FB_WIDTH-1].
bbox_min_y, bbox_max_y  output  [PIX_WIDTH-1:0]  clamped to [0, FB_HEIGHT-1].
vert_z  output  [2:0][COORD_WIDTH-1:0] signed  pass-through z, in accepted vertex order.
vert_inv_w  output  [2:0][COORD_WIDTH-1:0] signed  pass-through inv_w, in accepted vertex order.
valid  output  1  with done: triangle accepted.
busy  output  1  high from the cycle after start through DONE.
done  output  1  one-cycle completion pulse.
status  output  2  0 = ok, 1 = degenerate (area2 == 0), 2 = backface, 3 = off-screen.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE. Every output goes to 0: valid, busy, done, status, all coefficients, area2, bbox and pass-through fields.
- FSM: IDLE -> LOAD -> EDGE -> AREA -> CULL -> DONE -> IDLE. Each non-IDLE state lasts exactly one cycle.
- Latency: start is sampled high in IDLE at cycle T. done pulses at T+5 for exactly one cycle. busy is high during T+1..T+5. The bench must not re-issue start before T+6.
- IDLE: on start, register projected_verts; go to LOAD. start seen in any other state is ignored.
- LOAD: pixel coordinate = floor of Q16.16, i.e. bits [COORD_WIDTH-1:COORD_WIDTH/2], truncated/sign-preserving to PIX_WIDTH.
- EDGE: compute A, B and C for all three edges in parallel (six PIX_WIDTH x PIX_WIDTH signed multiplies). Full-width results, no saturation.
- AREA: area2 = sum of the three C values, sign-extended. Compute raw bbox = min and max of integer x and y.
- CULL, evaluated in this priority order:
  - area2 == 0 -> status 1.
  - area2 < 0 -> status 2 (see Optional Feature).
  - raw max_x < 0, raw min_x > FB_WIDTH-1, raw max_y < 0, or raw min_y > FB_HEIGHT-1 -> status 3.
  - Otherwise status 0. The clamped bbox is written.
- DONE: done = 1 and valid = (status == 0); busy drops the next cycle.
- Output hold: all data outputs and status hold their last value until the next accepted start.
- Culled triangles: coefficient outputs are still written, but the rasterizer ignores them because valid = 0.
- Winding: accepted triangles always have area2 > 0. A pixel (px, py) is inside when A_i*px + B_i*py + C_i >= 0 for all i.
- Reset mid-operation: abort immediately to IDLE with outputs zeroed. No done pulse is issued.

Optional Feature:
BACKFACE_CULL_EN
- Defined: area2 < 0 culls the triangle with status 2 and valid = 0.
- Undefined: area2 < 0 triangles are accepted (status 0). The block swaps vertices 1 and 2 by negating every A, B and C, negating area2, and exchanging vert_z[1]/vert_z[2] and vert_inv_w[1]/vert_inv_w[2].
- Both builds: area2 == 0 still culls with status 1.

Test Plan:
1. Verts (10,10), (20,10), (10,20); x/y = 0x000A0000, 0x00140000, etc. -> done at T+5, valid = 1, status 0, A = {0, -10, 10}, B = {10, -10, 0}, C = {-100, 300, -100}, area2 = 100, bbox x 10..20, y 10..20.
2. Same verts ordered (10,10), (10,20), (20,10):
   - With BACKFACE_CULL_EN -> valid = 0, status 2, area2 = -100.
   - Without it -> valid = 1, area2 = 100, coefficients equal to test 1, z/inv_w of v1 and v2 swapped.
3. Collinear (0,0), (5,5), (10,10) -> status 1, valid = 0, area2 = 0.
4. Verts (-50,10), (-40,10), (-50,20) -> status 3, valid = 0.
   Verts (-5,-5), (400,-5), (-5,300) -> status 0, bbox clamped to x 0..319, y 0..179.
5. Fractional inputs x = 0x000A8000 (10.5) and x = 0xFFFF8000 (-0.5) -> pixel x = 10 and -1 respectively (floor).
6. Assert rst_in low during EDGE -> all outputs 0 at once, no done pulse. A following start completes normally at T+5. A start pulsed while busy is ignored.
